usrp_tag_frame_sched: RTL and testbench

Frame scheduler for the tag-chip MTX transmit chain. It sequences one localization frame: a trigger, a pilot tone of PILOT_NSIG samples, then NLOC_PER_SYNC location slots of NSYMB symbols × NSIG samples each, separated by guard gaps. It generates the sample/symbol indices (`sigN`, `symbN`), the pilot/MTX select and the valid strobe that drive the phase-accumulator/DDS datapath. It also reports slot state on the front-panel GPIO and honours a GPIO abort line.

---
 rtl/usrp_tag_frame_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_usrp_tag_frame_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrp_tag_frame_sched.sv
// usrp_tag_frame_sched
// Sequences one localization frame for the MTX transmit chain:
// trigger, pilot tone, then NLOC_PER_SYNC location slots. Each slot is
// preceded by a guard gap and holds NSYMB symbols of NSIG samples.
// The block drives the sample/symbol indices, the pilot/MTX select and the
// valid strobe for the DDS datapath. It also mirrors slot state onto the
// front-panel GPIO.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-low
//   enable       start / continue frames (level, checked in IDLE and DONE)
//   tx_ready     downstream accepts the current sample
//   fp_gpio_in   bit0 = abort, other bits ignored
//   fp_gpio_out  {.., busy, tx_trig, pilot_sel, locN[3:0], 0}
//   fp_gpio_ddr  constant direction mask 12'h0FE
//   tx_trig      one-cycle frame-start pulse
//   tx_valid     indices describe a valid sample
//   pilot_sel    1 = pilot sample, 0 = MTX sample
//   sigN         sample index within pilot / symbol
//   symbN        symbol index within slot
//   locN         location slot index
//   busy         frame in progress
//   frame_done   one-cycle pulse on frame completion
module usrp_tag_frame_sched #(
    parameter int PHASE_WIDTH   = 24,
    parameter int NSYMB_WIDTH   = 16,
    parameter int REG_WIDTH     = 12,
    parameter int LOC_WIDTH     = 4,
    parameter int NSIG          = 8192,
    parameter int PILOT_NSIG    = 65536,
    parameter int NSYMB         = 24,
    parameter int NLOC_PER_SYNC = 3,
    parameter int GUARD         = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   tx_ready,
    input  logic [REG_WIDTH-1:0]   fp_gpio_in,
    output logic [REG_WIDTH-1:0]   fp_gpio_out,
    output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
    output logic                   tx_trig,
    output logic                   tx_valid,
    output logic                   pilot_sel,
    output logic [PHASE_WIDTH-1:0] sigN,
    output logic [NSYMB_WIDTH-1:0] symbN,
    output logic [LOC_WIDTH-1:0]   locN,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_PILOT = 3'd2,
        ST_GUARD = 3'd3,
        ST_SYMB  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int GUARD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    // Terminal counts; comparing against N-1 keeps every counter in range.
    localparam logic [PHASE_WIDTH-1:0] PILOT_LAST = PHASE_WIDTH'(PILOT_NSIG - 1);
    localparam logic [PHASE_WIDTH-1:0] SIG_LAST   = PHASE_WIDTH'(NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST  = NSYMB_WIDTH'(NSYMB - 1);
    localparam logic [LOC_WIDTH-1:0]   LOC_LAST   = LOC_WIDTH'(NLOC_PER_SYNC - 1);
    localparam logic [GUARD_W-1:0]     GUARD_LAST = GUARD_W'(GUARD - 1);

    state_t                 state_r, state_s;
    logic [PHASE_WIDTH-1:0] sig_r, sig_s;
    logic [NSYMB_WIDTH-1:0] symb_r, symb_s;
    logic [LOC_WIDTH-1:0]   loc_r, loc_s;
    logic [GUARD_W-1:0]     guard_r, guard_s;

    logic                   tx_trig_r, tx_valid_r, pilot_sel_r, busy_r, frame_done_r;
    logic                   tx_trig_s, tx_valid_s, pilot_sel_s, busy_s, frame_done_s;
    logic [REG_WIDTH-1:0]   gpio_out_r, gpio_out_s;

    logic                   beat_s;
    logic                   abort_s;
    logic                   unused_gpio_s;

    assign beat_s        = tx_valid_r & tx_ready;
    assign abort_s       = fp_gpio_in[0];
    assign unused_gpio_s = ^fp_gpio_in[REG_WIDTH-1:1];

    // Next-state and counter update for the frame sequencer.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        symb_s  = symb_r;
        loc_s   = loc_r;
        guard_s = guard_r;

        case (state_r)
            ST_IDLE: begin
                sig_s   = '0;
                symb_s  = '0;
                loc_s   = '0;
                guard_s = '0;
                // The abort bit also holds off a new start.
                if (enable && !abort_s) begin
                    state_s = ST_TRIG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRIG: begin
                state_s = ST_PILOT;
                sig_s   = '0;
                symb_s  = '0;
                loc_s   = '0;
                guard_s = '0;
            end
            ST_PILOT: begin
                if (beat_s) begin
                    if (sig_r == PILOT_LAST) begin
                        state_s = ST_GUARD;
                        sig_s   = '0;
                        guard_s = '0;
                    end else begin
                        sig_s = sig_r + PHASE_WIDTH'(1);
                    end
                end else begin
                    sig_s = sig_r;
                end
            end
            ST_GUARD: begin
                // Guard runs on clocks alone; tx_ready plays no part here.
                if (guard_r == GUARD_LAST) begin
                    state_s = ST_SYMB;
                    sig_s   = '0;
                    symb_s  = '0;
                    guard_s = '0;
                end else begin
                    guard_s = guard_r + GUARD_W'(1);
                end
            end
            ST_SYMB: begin
                if (beat_s) begin
                    if (sig_r == SIG_LAST) begin
                        sig_s = '0;
                        if (symb_r == SYMB_LAST) begin
                            symb_s  = '0;
                            guard_s = '0;
                            if (loc_r == LOC_LAST) begin
                                state_s = ST_DONE;
                                loc_s   = '0;
                            end else begin
                                state_s = ST_GUARD;
                                loc_s   = loc_r + LOC_WIDTH'(1);
                            end
                        end else begin
                            symb_s = symb_r + NSYMB_WIDTH'(1);
                        end
                    end else begin
                        sig_s = sig_r + PHASE_WIDTH'(1);
                    end
                end else begin
                    sig_s = sig_r;
                end
            end
            ST_DONE: begin
                sig_s   = '0;
                symb_s  = '0;
                loc_s   = '0;
                guard_s = '0;
                if (enable) begin
                    state_s = ST_TRIG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sig_s   = '0;
                symb_s  = '0;
                loc_s   = '0;
                guard_s = '0;
            end
        endcase

        // Abort outranks every transition outside IDLE.
        if (abort_s && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            sig_s   = '0;
            symb_s  = '0;
            loc_s   = '0;
            guard_s = '0;
        end else begin
            guard_s = guard_s;
        end
    end

    // Decode the next state into the values the output registers load.
    always_comb begin
        tx_trig_s    = (state_s == ST_TRIG);
        tx_valid_s   = (state_s == ST_PILOT) || (state_s == ST_SYMB);
        pilot_sel_s  = (state_s == ST_PILOT);
        busy_s       = (state_s != ST_IDLE);
        frame_done_s = (state_s == ST_DONE);
        gpio_out_s      = '0;
        gpio_out_s[4:1] = 4'(loc_s);
        gpio_out_s[5]   = pilot_sel_s;
        gpio_out_s[6]   = tx_trig_s;
        gpio_out_s[7]   = busy_s;
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            sig_r        <= '0;
            symb_r       <= '0;
            loc_r        <= '0;
            guard_r      <= '0;
            tx_trig_r    <= 1'b0;
            tx_valid_r   <= 1'b0;
            pilot_sel_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            gpio_out_r   <= '0;
        end else begin
            state_r      <= state_s;
            sig_r        <= sig_s;
            symb_r       <= symb_s;
            loc_r        <= loc_s;
            guard_r      <= guard_s;
            tx_trig_r    <= tx_trig_s;
            tx_valid_r   <= tx_valid_s;
            pilot_sel_r  <= pilot_sel_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            gpio_out_r   <= gpio_out_s;
        end
    end

    assign tx_trig     = tx_trig_r;
    assign tx_valid    = tx_valid_r;
    assign pilot_sel   = pilot_sel_r;
    assign sigN        = sig_r;
    assign symbN       = symb_r;
    assign locN        = loc_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign fp_gpio_out = gpio_out_r;
    assign fp_gpio_ddr = REG_WIDTH'(12'h0FE);

endmodule

// File: tb/tb_usrp_tag_frame_sched.sv
// Testbench for usrp_tag_frame_sched with a small frame
// (NSIG=4, PILOT_NSIG=8, NSYMB=2, NLOC_PER_SYNC=3, GUARD=2 -> 40 cycles).
module tb_usrp_tag_frame_sched;

    localparam int NS = 4;
    localparam int NP = 8;
    localparam int NY = 2;
    localparam int NL = 3;
    localparam int NG = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tx_ready;
    logic [11:0] fp_gpio_in;
    logic [11:0] fp_gpio_out;
    logic [11:0] fp_gpio_ddr;
    logic        tx_trig, tx_valid, pilot_sel, busy, frame_done;
    logic [23:0] sigN;
    logic [15:0] symbN;
    logic [3:0]  locN;

    int pass_cnt = 0;
    int total_cnt = 0;

    usrp_tag_frame_sched #(
        .NSIG(NS), .PILOT_NSIG(NP), .NSYMB(NY), .NLOC_PER_SYNC(NL), .GUARD(NG)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tx_ready(tx_ready),
        .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
        .tx_trig(tx_trig), .tx_valid(tx_valid), .pilot_sel(pilot_sel),
        .sigN(sigN), .symbN(symbN), .locN(locN), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef logic [72:0] ov_t;

    function automatic ov_t mk(input bit trig, input bit valid, input bit pilot,
                               input int sig, input int symb, input int loc,
                               input bit bsy, input bit done);
        logic [11:0] g;
        g      = 12'h000;
        g[4:1] = 4'(loc);
        g[5]   = pilot;
        g[6]   = trig;
        g[7]   = bsy;
        return {trig, valid, pilot, 24'(sig), 16'(symb), 4'(loc), bsy, done, g, 12'h0FE};
    endfunction

    function automatic ov_t dut_vec();
        return {tx_trig, tx_valid, pilot_sel, sigN, symbN, locN, busy, frame_done,
                fp_gpio_out, fp_gpio_ddr};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: queue of expected frame cycles -------
    localparam int K_TRIG = 0, K_PIL = 1, K_GRD = 2, K_MTX = 3, K_DONE = 4;
    typedef struct { int kind; int sig; int symb; int loc; } item_t;
    item_t q[$];

    function automatic void build_frame();
        item_t it;
        it = '{K_TRIG, 0, 0, 0};
        q.push_back(it);
        for (int i = 0; i < NP; i++) begin
            it = '{K_PIL, i, 0, 0};
            q.push_back(it);
        end
        for (int l = 0; l < NL; l++) begin
            for (int g = 0; g < NG; g++) begin
                it = '{K_GRD, 0, 0, l};
                q.push_back(it);
            end
            for (int s = 0; s < NY; s++) begin
                for (int n = 0; n < NS; n++) begin
                    it = '{K_MTX, n, s, l};
                    q.push_back(it);
                end
            end
        end
        it = '{K_DONE, 0, 0, 0};
        q.push_back(it);
    endfunction

    // Advance the model across one clock edge given the inputs seen there.
    function automatic void model_step(input bit rst_n, input bit en, input bit rdy, input bit ab);
        item_t h;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (en && !ab) build_frame();
        end else if (ab) begin
            q.delete();
        end else begin
            h = q[0];
            if (h.kind == K_PIL || h.kind == K_MTX) begin
                if (rdy) void'(q.pop_front());
            end else begin
                void'(q.pop_front());
                if (h.kind == K_DONE && en) build_frame();
            end
        end
    endfunction

    function automatic ov_t model_out();
        if (q.size() == 0) return mk(0, 0, 0, 0, 0, 0, 0, 0);
        case (q[0].kind)
            K_TRIG:  return mk(1, 0, 0, 0, 0, 0, 1, 0);
            K_PIL:   return mk(0, 1, 1, q[0].sig, 0, 0, 1, 0);
            K_GRD:   return mk(0, 0, 0, 0, 0, q[0].loc, 1, 0);
            K_MTX:   return mk(0, 1, 0, q[0].sig, q[0].symb, q[0].loc, 1, 0);
            default: return mk(0, 0, 0, 0, 0, 0, 1, 1);
        endcase
    endfunction

    // ---------------- frame statistics helper for tests 2/3 -----------------
    // Entered in the TRIG cycle; leaves in the frame_done cycle.
    task automatic run_frame(input bit alt, output int trig_n, output int pil_beats,
                             output int mtx_beats, output int seq_err, output int gap_n,
                             output int pil_span, output int done_at);
        trig_n = 0; pil_beats = 0; mtx_beats = 0; seq_err = 0;
        gap_n = 0; pil_span = 0; done_at = -1;
        for (int c = 0; c < 400; c++) begin
            tx_ready = alt ? (c % 2 == 0) : 1'b1;
            if (tx_trig) trig_n++;
            if (tx_valid && pilot_sel) begin
                pil_span++;
                if (tx_ready) begin
                    if (sigN != 24'(pil_beats) || symbN != 16'd0 || locN != 4'd0) seq_err++;
                    pil_beats++;
                end
            end
            if (tx_valid && !pilot_sel && tx_ready) begin
                if (sigN != 24'(mtx_beats % NS) || symbN != 16'((mtx_beats / NS) % NY) ||
                    locN != 4'(mtx_beats / (NS * NY))) seq_err++;
                mtx_beats++;
            end
            if (busy && !tx_valid && !tx_trig && !frame_done) gap_n++;
            if (frame_done) begin
                done_at = c;
                break;
            end
            tick();
        end
        tx_ready = 1'b1;
    endtask

    typedef struct {
        bit rst; bit en; bit rdy; bit ab;
        bit trig; bit valid; bit pilot; int sig; bit bsy; bit done;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int tn, pb, mb, se, gn, ps, da;
        int d1, d2, after_trig, done_n, busy_n;
        bit prev_done, found;
        bit r_rst, r_en, r_rdy, r_ab;

        reset = 1'b0; enable = 1'b1; tx_ready = 1'b1; fp_gpio_in = 12'h000;

        // rst en rdy ab | trig valid pilot sig busy done
        tbl[0]  = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[1]  = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[2]  = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[3]  = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[4]  = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[5]  = '{1,1,1,0, 1,0,0,0,1,0};
        tbl[6]  = '{1,0,1,0, 0,1,1,0,1,0};
        tbl[7]  = '{1,0,1,0, 0,1,1,1,1,0};
        tbl[8]  = '{1,0,0,0, 0,1,1,1,1,0};
        tbl[9]  = '{1,0,0,0, 0,1,1,1,1,0};
        tbl[10] = '{1,0,1,0, 0,1,1,2,1,0};
        tbl[11] = '{1,0,1,0, 0,1,1,3,1,0};
        tbl[12] = '{0,1,1,0, 0,0,0,0,0,0};
        tbl[13] = '{1,1,1,1, 0,0,0,0,0,0};
        tbl[14] = '{1,1,1,0, 1,0,0,0,1,0};
        tbl[15] = '{1,0,1,0, 0,1,1,0,1,0};
        tbl[16] = '{1,0,1,0, 0,1,1,1,1,0};
        tbl[17] = '{1,0,1,1, 0,0,0,0,0,0};
        tbl[18] = '{1,0,1,0, 0,0,0,0,0,0};

        for (int i = 0; i < 19; i++) begin
            reset      = tbl[i].rst;
            enable     = tbl[i].en;
            tx_ready   = tbl[i].rdy;
            fp_gpio_in = {11'h000, tbl[i].ab};
            tick();
            chk($sformatf("tbl_row%0d", i), 128'(dut_vec()),
                128'(mk(tbl[i].trig, tbl[i].valid, tbl[i].pilot, tbl[i].sig, 0, 0,
                        tbl[i].bsy, tbl[i].done)));
        end
        fp_gpio_in = 12'h000; enable = 1'b0; reset = 1'b1;

        // Test 2: single frame, tx_ready high, enable pulsed one cycle.
        enable = 1'b1; tick(); enable = 1'b0;
        chk("t2_trig_first", 128'(tx_trig), 128'(1));
        run_frame(1'b0, tn, pb, mb, se, gn, ps, da);
        chk("t2_trig_cycles", 128'(tn), 128'(1));
        chk("t2_pilot_beats", 128'(pb), 128'(NP));
        chk("t2_mtx_beats", 128'(mb), 128'(NL * NY * NS));
        chk("t2_index_seq", 128'(se), 128'(0));
        chk("t2_guard_cycles", 128'(gn), 128'(NL * NG));
        chk("t2_pilot_span", 128'(ps), 128'(NP));
        chk("t2_done_at", 128'(da), 128'(39));
        chk("t2_done_no_trig", 128'(tx_trig), 128'(0));
        tick();
        chk("t2_idle_after", 128'(dut_vec()), 128'(mk(0, 0, 0, 0, 0, 0, 0, 0)));

        // Test 3: alternating backpressure.
        enable = 1'b1; tick(); enable = 1'b0;
        run_frame(1'b1, tn, pb, mb, se, gn, ps, da);
        chk("t3_pilot_beats", 128'(pb), 128'(NP));
        chk("t3_mtx_beats", 128'(mb), 128'(NL * NY * NS));
        chk("t3_index_hold", 128'(se), 128'(0));
        chk("t3_guard_cycles", 128'(gn), 128'(NL * NG));
        chk("t3_pilot_span", 128'(ps), 128'(2 * NP));
        chk("t3_trig_cycles", 128'(tn), 128'(1));
        tick();
        chk("t3_idle_after", 128'(busy), 128'(0));

        // Test 4: enable held high, back-to-back frames.
        enable = 1'b1; tx_ready = 1'b1; tick();
        d1 = -1; d2 = -1; after_trig = -1; prev_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (prev_done && after_trig < 0) after_trig = int'(tx_trig);
            prev_done = frame_done;
            if (frame_done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) begin d2 = i; enable = 1'b0; end
            end
            if (d2 >= 0) break;
            tick();
        end
        chk("t4_trig_after_done", 128'(after_trig), 128'(1));
        chk("t4_done_spacing", 128'(d2 - d1), 128'(40));
        tick();
        chk("t4_idle_after", 128'(busy), 128'(0));

        // Test 5: abort while locN=1 in SYMB, then abort in IDLE.
        enable = 1'b1; tick(); enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid && !pilot_sel && locN == 4'd1) begin found = 1'b1; break; end
            tick();
        end
        chk("t5_reached_loc1", 128'(found), 128'(1));
        fp_gpio_in = 12'h001; tick(); fp_gpio_in = 12'h000;
        chk("t5_abort_clears", 128'(dut_vec()), 128'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            done_n += int'(frame_done);
            busy_n += int'(busy);
        end
        chk("t5_no_frame_done", 128'(done_n), 128'(0));
        chk("t5_stays_idle", 128'(busy_n), 128'(0));
        fp_gpio_in = 12'h001; enable = 1'b1;
        tick();
        chk("t5_idle_abort_no_trig", 128'(tx_trig), 128'(0));
        tick();
        chk("t5_idle_abort_no_busy", 128'(busy), 128'(0));
        fp_gpio_in = 12'h000; enable = 1'b0;

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_ab  = ($urandom_range(0, 199) == 0);
            reset = r_rst; enable = r_en; tx_ready = r_rdy;
            fp_gpio_in = {11'($urandom), r_ab};
            model_step(r_rst, r_en, r_rdy, r_ab);
            tick();
            chk($sformatf("rand_cyc%0d", i), 128'(dut_vec()), 128'(model_out()));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
